pulse_dispatcher: RTL

PULSE_DISPATCHER -- requirements
Module: pulse_dispatcher

---
 rtl/pulse_dispatcher.sv | 148 ++++++++++++++
 1 files changed

// File: rtl/pulse_dispatcher.sv
// Pulse dispatcher: pops one pulse descriptor, waits for its start time, then
// streams per-sample phase/amplitude/envelope beats with valid/ready handshaking.
module pulse_dispatcher #(
  parameter int FREQ_W   = 32,
  parameter int PHASE_W  = 32,
  parameter int AMP_W    = 16,
  parameter int TSTART_W = 32,
  parameter int TLEN_W   = 16,
  parameter int ENV_W    = 10
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [TSTART_W-1:0] counter,
  input  logic                pr_empty,
  input  logic [FREQ_W-1:0]   pr_freq,
  input  logic [PHASE_W-1:0]  pr_phase,
  input  logic [AMP_W-1:0]    pr_amp,
  input  logic [TSTART_W-1:0] pr_tstart,
  input  logic [TLEN_W-1:0]   pr_tlen,
  input  logic [ENV_W-1:0]    pr_env,
  output logic                pr_rd_en,
  output logic                m_valid,
  input  logic                m_ready,
  output logic [PHASE_W-1:0]  m_phase,
  output logic [AMP_W-1:0]    m_amp,
  output logic [ENV_W-1:0]    m_env_addr,
  output logic                m_last,
  output logic                busy,
  output logic                late_err,
  output logic [15:0]         pulse_cnt
);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_PLAY} state_e;

  state_e                state_q,     state_d;
  logic [FREQ_W-1:0]     freq_q,      freq_d;
  logic [PHASE_W-1:0]    phase_q,     phase_d;
  logic [AMP_W-1:0]      amp_q,       amp_d;
  logic [TSTART_W-1:0]   tstart_q,    tstart_d;
  logic [TLEN_W-1:0]     tlen_q,      tlen_d;
  logic [ENV_W-1:0]      env_q,       env_d;
  logic [PHASE_W-1:0]    phase_acc_q, phase_acc_d;
  logic [TLEN_W-1:0]     idx_q,       idx_d;
  logic                  late_err_q,  late_err_d;
  logic [15:0]           pulse_cnt_q, pulse_cnt_d;

  logic [TSTART_W-1:0]   d_time;
  logic                  is_last;

  // Wrapped difference: MSB set means t_start is still in the future.
  assign d_time  = counter - tstart_q;
  assign is_last = (idx_q == (tlen_q - TLEN_W'(1)));

  assign m_valid    = (state_q == S_PLAY);
  assign m_last     = m_valid && is_last;
  assign m_phase    = phase_acc_q;
  assign m_amp      = amp_q;
  assign m_env_addr = env_q + ENV_W'(idx_q);
  assign busy       = (state_q != S_IDLE);
  assign late_err   = late_err_q;
  assign pulse_cnt  = pulse_cnt_q;

  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned (no latches).
    state_d     = state_q;
    freq_d      = freq_q;
    phase_d     = phase_q;
    amp_d       = amp_q;
    tstart_d    = tstart_q;
    tlen_d      = tlen_q;
    env_d       = env_q;
    phase_acc_d = phase_acc_q;
    idx_d       = idx_q;
    late_err_d  = late_err_q;
    pulse_cnt_d = pulse_cnt_q;
    pr_rd_en    = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        // Gated by rst so an entry is never popped while reset is held.
        if (!pr_empty && !rst) begin
          pr_rd_en = 1'b1;
          freq_d   = pr_freq;
          phase_d  = pr_phase;
          amp_d    = pr_amp;
          tstart_d = pr_tstart;
          tlen_d   = pr_tlen;
          env_d    = pr_env;
          state_d  = S_WAIT;
        end
      end
      S_WAIT: begin
        if (!d_time[TSTART_W-1]) begin
          if (d_time != '0) late_err_d = 1'b1;
          phase_acc_d = phase_q;
          idx_d       = '0;
          if (tlen_q == '0) begin
            state_d     = S_IDLE;
            pulse_cnt_d = pulse_cnt_q + 16'd1;
          end else begin
            state_d = S_PLAY;
          end
        end
      end
      S_PLAY: begin
        if (m_ready) begin
          phase_acc_d = phase_acc_q + PHASE_W'(freq_q);
          idx_d       = idx_q + TLEN_W'(1);
          if (is_last) begin
            state_d     = S_IDLE;
            pulse_cnt_d = pulse_cnt_q + 16'd1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments so all flops update together on the edge.
    if (rst) begin
      state_q     <= S_IDLE;
      freq_q      <= '0;
      phase_q     <= '0;
      amp_q       <= '0;
      tstart_q    <= '0;
      tlen_q      <= '0;
      env_q       <= '0;
      phase_acc_q <= '0;
      idx_q       <= '0;
      late_err_q  <= 1'b0;
      pulse_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      freq_q      <= freq_d;
      phase_q     <= phase_d;
      amp_q       <= amp_d;
      tstart_q    <= tstart_d;
      tlen_q      <= tlen_d;
      env_q       <= env_d;
      phase_acc_q <= phase_acc_d;
      idx_q       <= idx_d;
      late_err_q  <= late_err_d;
      pulse_cnt_q <= pulse_cnt_d;
    end
  end

endmodule
